barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator: the next generation of the team's fixed 8-bit left rotator. Supports any power-of-two width, four shift modes (rotate left, rotate right, logical left, arithmetic right), one registered stage per shift-amount bit, and a valid/ready handshake with backpressure. It sits between a producer and consumer on the datapath and replaces the combinational rotator wherever timing or flow control is needed.

---
 rtl/barrel_shift_pipe.sv | 87 ++++++++
 tb/tb_barrel_shift_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready flow control.
// One register stage per shift-amount bit; a global stall freezes all stages.
module barrel_shift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;

  logic [WIDTH-1:0] data_q  [SHW];
  logic             valid_q [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic [1:0]       mode_q  [SHW];
  logic             sign_q  [SHW];

  logic advance;
  logic unused_tail;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic             s,
    input int               sh
  );
    logic [WIDTH-1:0] fill;
    fill = s ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (m)
      MODE_ROL: step = (d << sh) | (d >> (WIDTH - sh));
      MODE_ROR: step = (d >> sh) | (d << (WIDTH - sh));
      MODE_SLL: step = d << sh;
      default:  step = (d >> sh) | fill;
    endcase
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = out_valid && (data_q[SHW-1] == '0);

  // Consumed amt bits are shifted out so each stage reads bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        sign_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_amt[0]
                    ? step(in_data, in_mode, in_data[WIDTH-1], 1)
                    : in_data;
      amt_q[0]   <= in_amt >> 1;
      mode_q[0]  <= in_mode;
      sign_q[0]  <= in_data[WIDTH-1];
      for (int k = 1; k < SHW; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= amt_q[k-1][0]
                      ? step(data_q[k-1], mode_q[k-1], sign_q[k-1], 1 << k)
                      : data_q[k-1];
        amt_q[k]   <= amt_q[k-1] >> 1;
        mode_q[k]  <= mode_q[k-1];
        sign_q[k]  <= sign_q[k-1];
      end
    end
  end

  assign unused_tail = ^{amt_q[SHW-1], mode_q[SHW-1], sign_q[SHW-1]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and scoreboarded checks for barrel_shift_pipe.
// Main DUT is WIDTH=8; WIDTH=16 and 32 instances cover the width sweep.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_data, out_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;

  logic        v16, r16, ov16, oz16, v32, r32, ov32, oz32;
  logic [15:0] d16, od16;
  logic [31:0] d32, od32;
  logic [3:0]  a16;
  logic [4:0]  a32;
  logic [1:0]  m16, m32;

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  barrel_shift_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(r16),
    .in_data(d16), .in_amt(a16), .in_mode(m16),
    .out_valid(ov16), .out_ready(1'b1),
    .out_data(od16), .out_zero(oz16)
  );

  barrel_shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32), .in_ready(r32),
    .in_data(d32), .in_amt(a32), .in_mode(m32),
    .out_valid(ov32), .out_ready(1'b1),
    .out_data(od32), .out_zero(oz32)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_in8    = 0;
  int n_out8   = 0;
  int drops    = 0;
  int cyc      = 0;
  bit stream_on = 0;

  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic [31:0] q32[$];

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] e;
    logic       z;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int a,
                                        input logic [1:0] m, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00: r[i] = d[(i - a + w) % w];
        2'b01: r[i] = d[(i + a) % w];
        2'b10: r[i] = (i >= a) ? d[i - a] : 1'b0;
        default: r[i] = (i + a < w) ? d[i + a] : d[w - 1];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboards: sampled mid-cycle for the handshake at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stream_on && !in_ready) drops++;
      if (out_valid && out_ready) begin
        if (q8.size() == 0) chk("sb8_unexpected", 32'(out_data), 32'hdead);
        else begin
          logic [31:0] e;
          e = q8.pop_front();
          chk("sb8_data", 32'(out_data), e);
          chk("sb8_zero", 32'(out_zero), 32'(e == 0));
          n_out8++;
        end
      end
      if (in_valid && in_ready) begin
        q8.push_back(model(32'(in_data), int'(in_amt), in_mode, 8));
        n_in8++;
      end
      if (ov16) begin
        if (q16.size() == 0) chk("sb16_unexpected", 32'(od16), 32'hdead);
        else chk("sb16_data", 32'(od16), q16.pop_front());
      end
      if (v16 && r16) q16.push_back(model(32'(d16), int'(a16), m16, 16));
      if (ov32) begin
        if (q32.size() == 0) chk("sb32_unexpected", od32, 32'hdead);
        else chk("sb32_data", od32, q32.pop_front());
      end
      if (v32 && r32) q32.push_back(model(d32, int'(a32), m32, 32));
    end
  end

  task automatic send8(input logic [7:0] d, input logic [2:0] a,
                       input logic [1:0] m);
    int t;
    logic acc;
    t = 0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain8();
    int t;
    t = 0;
    while ((q8.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain8_empty", 32'(q8.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    send8(v.d, v.a, v.m);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd3);
    chk({nm, "_data"}, 32'(out_data), 32'(v.e));
    chk({nm, "_zero"}, 32'(out_zero), 32'(v.z));
  endtask

  task automatic wide_latency();
    int l16, l32;
    v16 = 1'b1; d16 = 16'h8001; a16 = 4'd15; m16 = 2'b00;
    v32 = 1'b1; d32 = 32'h8000_0001; a32 = 5'd31; m32 = 2'b11;
    @(posedge clk); #1;
    v16 = 1'b0; v32 = 1'b0;
    l16 = 0; l32 = 0;
    for (int c = 1; c < 12; c++) begin
      if (ov16 && l16 == 0) l16 = c;
      if (ov32 && l32 == 0) l32 = c;
      @(posedge clk); #1;
    end
    chk("lat16", 32'(l16), 32'd4);
    chk("lat32", 32'(l32), 32'd5);
  endtask

  initial begin
    vt[0]  = '{8'hB4, 3'd3, 2'b00, 8'hA5, 1'b0};
    vt[1]  = '{8'hB4, 3'd3, 2'b01, 8'h96, 1'b0};
    vt[2]  = '{8'hB4, 3'd3, 2'b10, 8'hA0, 1'b0};
    vt[3]  = '{8'hB4, 3'd3, 2'b11, 8'hF6, 1'b0};
    vt[4]  = '{8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0};
    vt[5]  = '{8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0};
    vt[6]  = '{8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0};
    vt[7]  = '{8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0};
    vt[8]  = '{8'h80, 3'd1, 2'b10, 8'h00, 1'b1};
    vt[9]  = '{8'h01, 3'd1, 2'b01, 8'h80, 1'b0};
    vt[10] = '{8'h80, 3'd7, 2'b11, 8'hFF, 1'b0};
    vt[11] = '{8'h7F, 3'd7, 2'b11, 8'h00, 1'b1};
    vt[12] = '{8'h81, 3'd7, 2'b00, 8'hC0, 1'b0};

    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
    v16 = 1'b0; d16 = '0; a16 = '0; m16 = '0;
    v32 = 1'b0; d32 = '0; a32 = '0; m32 = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));
    drain8();

    // Back-to-back streaming at full rate.
    begin
      int c0;
      stream_on = 1;
      c0 = cyc;
      for (int i = 0; i < 64; i++)
        send8(8'($urandom), 3'($urandom), 2'($urandom));
      chk("stream_cycles", 32'(cyc - c0), 32'd64);
      stream_on = 0;
      chk("stream_in_ready", 32'(drops), 32'd0);
      drain8();
    end

    // Fixed 5-cycle stall with a beat waiting at the input.
    begin
      logic [7:0] held;
      send8(8'h11, 3'd1, 2'b00);
      send8(8'h22, 3'd2, 2'b01);
      send8(8'h33, 3'd3, 2'b11);
      in_valid = 1'b1; in_data = 8'h44; in_amt = 3'd4; in_mode = 2'b10;
      out_ready = 1'b0;
      held = out_data;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_hold", 32'(out_data), 32'(held));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send8(8'h44, 3'd4, 2'b10);
      drain8();
    end

    // Random backpressure at 50% duty.
    begin
      bit done;
      done = 0;
      fork
        begin
          for (int i = 0; i < 60; i++)
            send8(8'($urandom), 3'($urandom), 2'($urandom));
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1'b1;
      drain8();
      chk("count_in_out", 32'(n_out8), 32'(n_in8));
    end

    // Reset with three beats in flight.
    begin
      vec_t v;
      send8(8'hC3, 3'd1, 2'b00);
      send8(8'h3C, 3'd2, 2'b01);
      send8(8'hF0, 3'd3, 2'b10);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_out_zero", 32'(out_zero), 32'd0);
      q8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      v = '{8'h96, 3'd5, 2'b11, 8'hFC, 1'b0};
      run_vec(v, "postrst");
      drain8();
    end

    // Width sweep.
    wide_latency();
    for (int i = 0; i < 40; i++) begin
      v16 = 1'b1; d16 = 16'($urandom); m16 = 2'($urandom);
      a16 = (i % 5 == 0) ? 4'd15 : 4'($urandom);
      v32 = 1'b1; d32 = $urandom; m32 = 2'($urandom);
      a32 = (i % 5 == 0) ? 5'd31 : 5'($urandom);
      @(posedge clk); #1;
    end
    v16 = 1'b0; v32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q32_empty", 32'(q32.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
